// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory port: FSM states,
// byte-lane enable patterns and the MemSize encodings from the decoder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    localparam logic       SIZE_BYTE = 1'b0;
    localparam logic       SIZE_WORD = 1'b1;

    localparam logic [3:0] SEL_NONE  = 4'b0000;
    localparam logic [3:0] SEL_BYTE0 = 4'b0001;
    localparam logic [3:0] SEL_WORD  = 4'b1111;

    // Sign-extend one byte to a 32-bit load result.
    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational little-endian lane steering: byte enables and replicated
// store data on the way out, sign-extended byte extraction on the way in.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic        size_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  sel_o,
    output logic [31:0] sdat_o,
    output logic [31:0] ldat_o,
    output logic        misal_o
);

    // Word accesses use all lanes; byte accesses pick the lane named by the offset.
    always_comb begin
        sel_o   = SEL_NONE;
        sdat_o  = 32'd0;
        ldat_o  = 32'd0;
        misal_o = 1'b0;
        if (size_i == SIZE_WORD) begin
            sel_o   = SEL_WORD;
            sdat_o  = wdata_i;
            ldat_o  = wb_dat_i;
            misal_o = (off_i != 2'b00);
        end else begin
            sel_o  = SEL_BYTE0 << off_i;
            sdat_o = {4{wdata_i[7:0]}};
            case (off_i)
                2'd0:    ldat_o = sext8(wb_dat_i[7:0]);
                2'd1:    ldat_o = sext8(wb_dat_i[15:8]);
                2'd2:    ldat_o = sext8(wb_dat_i[23:16]);
                default: ldat_o = sext8(wb_dat_i[31:24]);
            endcase
        end
    end

endmodule

// File: rtl/data_mem_port.sv
// Wishbone-classic master executing decoder loads/stores. Holds the pipeline
// while an access is outstanding, aborts misaligned words and bus timeouts
// with err, and returns steered load data together with a one-cycle done.
module data_mem_port
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    localparam int unsigned      CNT_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic             TO_EN  = (TIMEOUT_CYCLES != 0);

    mem_state_e       state_q;
    logic             cyc_q;
    logic             we_q;
    logic [31:0]      adr_q;
    logic [31:0]      dat_q;
    logic [3:0]       sel_q;
    logic [1:0]       off_q;
    logic             size_q;
    logic             done_q;
    logic             err_q;
    logic [31:0]      rdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             req;
    logic [1:0]       al_off;
    logic             al_size;
    logic [3:0]       al_sel;
    logic [31:0]      al_sdat;
    logic [31:0]      al_ldat;
    logic             al_misal;

    assign req = mem_read | mem_write;

    // Live request fields steer lanes in IDLE; the latched ones steer the returning load.
    always_comb begin
        al_off  = off_q;
        al_size = size_q;
        cnt_d   = cnt_q + 1'b1;
        if (state_q == IDLE) begin
            al_off  = addr[1:0];
            al_size = mem_size;
        end
    end

    mem_lane_align u_align (
        .off_i    (al_off),
        .size_i   (al_size),
        .wdata_i  (wdata),
        .wb_dat_i (wb_dat_i),
        .sel_o    (al_sel),
        .sdat_o   (al_sdat),
        .ldat_o   (al_ldat),
        .misal_o  (al_misal)
    );

    // Access FSM with registered bus signals, completion pulses and timeout counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 32'd0;
            dat_q   <= 32'd0;
            sel_q   <= SEL_NONE;
            off_q   <= 2'd0;
            size_q  <= SIZE_BYTE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (al_misal) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= 32'd0;
                        end else begin
                            state_q <= BUS;
                            cyc_q   <= 1'b1;
                            we_q    <= mem_write;
                            adr_q   <= {addr[31:2], 2'b00};
                            sel_q   <= al_sel;
                            dat_q   <= mem_write ? al_sdat : 32'd0;
                            off_q   <= addr[1:0];
                            size_q  <= mem_size;
                            cnt_q   <= '0;
                        end
                    end
                end
                BUS: begin
                    if (wb_ack_i) begin
                        state_q <= DONE;
                        cyc_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        rdata_q <= we_q ? 32'd0 : al_ldat;
                    end else begin
                        cnt_q <= cnt_d;
                        if (TO_EN && (cnt_d == TO_LIM)) begin
                            state_q <= DONE;
                            cyc_q   <= 1'b0;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= 32'd0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    cyc_q   <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign stall    = ((state_q == IDLE) && req) || (state_q == BUS);
    assign done     = done_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: table of single accesses plus hand-written
// timeout and mid-access reset sequences.
module tb_data_mem_port;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic        mem_size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    int n_chk;
    int n_fail;
    int cur;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] dati;
        int          waits;
        logic        bus;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dato;
        logic [31:0] rdata;
        logic        err;
        logic        ck_rd;
    } vec_t;

    vec_t vecs[11];

    data_mem_port #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_size  (mem_size),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", cur, nm, act, exp);
        end
    endtask

    // Entered and left at posedge+1; the request is presented in cycle 0.
    task automatic do_txn(input vec_t v);
        mem_read  = v.rd;
        mem_write = v.wr;
        mem_size  = v.sz;
        addr      = v.addr;
        wdata     = v.wdata;
        @(negedge clk);
        chk("c0_stall", {31'd0, stall}, 32'd1);
        chk("c0_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("c0_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        if (v.bus) begin
            for (int w = 0; w <= v.waits; w++) begin
                if (w == v.waits) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = v.dati;
                end else begin
                    wb_dat_i = 32'h5A5A_5A5A;
                end
                @(negedge clk);
                chk("bus_cyc", {31'd0, wb_cyc_o}, 32'd1);
                chk("bus_stb", {31'd0, wb_stb_o}, 32'd1);
                chk("bus_stall", {31'd0, stall}, 32'd1);
                chk("bus_done", {31'd0, done}, 32'd0);
                chk("bus_we", {31'd0, wb_we_o}, {31'd0, v.we});
                chk("bus_sel", {28'd0, wb_sel_o}, {28'd0, v.sel});
                chk("bus_adr", wb_adr_o, v.adr);
                chk("bus_dat_o", wb_dat_o, v.dato);
                @(posedge clk); #1;
            end
            wb_ack_i = 1'b0;
        end
        @(negedge clk);
        chk("done", {31'd0, done}, 32'd1);
        chk("err", {31'd0, err}, {31'd0, v.err});
        chk("done_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("done_stall", {31'd0, stall}, 32'd0);
        if (v.ck_rd) chk("rdata", rdata, v.rdata);
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        chk("after_done", {31'd0, done}, 32'd0);
        chk("after_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("after_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        cur = -1;
        //            rd wr sz addr          wdata         dati          w  bus we sel    adr           dato          rdata         err ck
        vecs[0]  = '{1, 0, 1, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1, 0, 4'hF, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1};
        vecs[1]  = '{1, 0, 0, 32'h0000_0103, 32'h0,        32'h8011_2233, 0, 1, 0, 4'h8, 32'h0000_0100, 32'h0,        32'hFFFF_FF80, 0, 1};
        vecs[2]  = '{1, 0, 0, 32'h0000_0101, 32'h0,        32'h8011_2233, 0, 1, 0, 4'h2, 32'h0000_0100, 32'h0,        32'h0000_0022, 0, 1};
        vecs[3]  = '{0, 1, 0, 32'h0000_0202, 32'h1234_56AB, 32'h0,        3, 1, 1, 4'h4, 32'h0000_0200, 32'hABAB_ABAB, 32'h0,        0, 0};
        vecs[4]  = '{0, 1, 1, 32'h0000_0205, 32'h1111_2222, 32'h0,        0, 0, 0, 4'h0, 32'h0,        32'h0,        32'h0,        1, 1};
        vecs[5]  = '{1, 0, 0, 32'h0000_0102, 32'h0,        32'h00FF_7F00, 1, 1, 0, 4'h4, 32'h0000_0100, 32'h0,        32'hFFFF_FFFF, 0, 1};
        vecs[6]  = '{1, 0, 0, 32'h0000_0100, 32'h0,        32'h1234_567F, 0, 1, 0, 4'h1, 32'h0000_0100, 32'h0,        32'h0000_007F, 0, 1};
        vecs[7]  = '{0, 1, 1, 32'h0000_0208, 32'hCAFE_F00D, 32'h0,        2, 1, 1, 4'hF, 32'h0000_0208, 32'hCAFE_F00D, 32'h0,        0, 0};
        vecs[8]  = '{0, 1, 0, 32'h0000_020D, 32'h0000_00C3, 32'h0,        0, 1, 1, 4'h2, 32'h0000_020C, 32'hC3C3_C3C3, 32'h0,        0, 0};
        vecs[9]  = '{1, 0, 1, 32'h0000_0102, 32'h0,        32'h0,        0, 0, 0, 4'h0, 32'h0,        32'h0,        32'h0,        1, 1};
        vecs[10] = '{1, 1, 1, 32'h0000_0400, 32'h1122_3344, 32'h0,        1, 1, 1, 4'hF, 32'h0000_0400, 32'h1122_3344, 32'h0,        0, 0};

        reset     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_size  = 1'b0;
        addr      = 32'd0;
        wdata     = 32'd0;
        wb_dat_i  = 32'd0;
        wb_ack_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("rst_we", {31'd0, wb_we_o}, 32'd0);
        chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_dat_o", wb_dat_o, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            cur = i;
            do_txn(vecs[i]);
        end

        // Word load with no acknowledge: four BUS cycles, then abort with err.
        cur = 100;
        mem_read = 1'b1;
        mem_size = 1'b1;
        addr     = 32'h0000_0300;
        wb_dat_i = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("to_c0_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_cyc", {31'd0, wb_cyc_o}, 32'd1);
            chk("to_stall", {31'd0, stall}, 32'd1);
            chk("to_done_early", {31'd0, done}, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
        chk("to_done", {31'd0, done}, 32'd1);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        mem_read = 1'b0;
        @(negedge clk);
        chk("to_after_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        cur = 101;
        do_txn(vecs[0]);

        // Reset while the bus cycle is open, then a stray ack after release.
        cur = 200;
        mem_read = 1'b1;
        mem_size = 1'b1;
        addr     = 32'h0000_0500;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mr_cyc_before", {31'd0, wb_cyc_o}, 32'd1);
        #2;
        mem_read = 1'b0;
        reset    = 1'b0;
        #1;
        chk("mr_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("mr_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("mr_done", {31'd0, done}, 32'd0);
        chk("mr_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        reset    = 1'b1;
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h7777_7777;
        @(negedge clk);
        chk("mr_ack_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
        @(negedge clk);
        chk("mr_stray_done", {31'd0, done}, 32'd0);
        chk("mr_stray_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("mr_stray_rdata", rdata, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
